// File: rtl/rv32_writeback_unit_if.sv
// rtl/rv32_writeback_unit_if.sv - MEM-to-WB retire handshake bundle
// The master drives the retiring instruction; the slave (writeback unit) returns wb_ready.
interface rv32_writeback_unit_if #(
   parameter int XLEN = 32
);
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_rd;
   logic [1:0]      wb_src;
   logic [XLEN-1:0] wb_alu_result;
   logic [XLEN-1:0] wb_pc4;
   logic [2:0]      wb_funct3;

   modport master (
      output wb_valid, wb_rd, wb_src, wb_alu_result, wb_pc4, wb_funct3,
      input  wb_ready
   );

   modport slave (
      input  wb_valid, wb_rd, wb_src, wb_alu_result, wb_pc4, wb_funct3,
      output wb_ready
   );
endinterface

// File: rtl/rv32_writeback_unit.sv
// rtl/rv32_writeback_unit.sv - RV32 WB stage: result select, load wait/extend, regfile write
// Optional retire counter (instret) built only when RV32_WB_PERF_EN is defined.
module rv32_writeback_unit #(
   parameter int XLEN       = 32,
   parameter int PERF_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   rv32_writeback_unit_if.slave  wb,
   input  logic                  dmem_rvalid,
   input  logic [XLEN-1:0]       dmem_rdata,
   output logic                  write_reg,
   output logic [4:0]            sel_d1,
   output logic [XLEN-1:0]       reg_d1,
   output logic                  pend_valid,
   output logic [4:0]            pend_rd,
   output logic                  load_fault,
   output logic                  spurious_rsp,
   output logic [PERF_WIDTH-1:0] instret
);
   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;
   localparam logic [1:0] SRC_NONE = 2'b11;

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

   state_t          state_q, state_d;
   logic            write_reg_q, write_reg_d;
   logic [4:0]      sel_d1_q, sel_d1_d;
   logic [XLEN-1:0] reg_d1_q, reg_d1_d;
   logic            pend_valid_q, pend_valid_d;
   logic [4:0]      pend_rd_q, pend_rd_d;
   logic [2:0]      ld_funct3_q, ld_funct3_d;
   logic [1:0]      ld_addr_q, ld_addr_d;
   logic            load_fault_q, load_fault_d;
   logic            spurious_q, spurious_d;

   logic accept, is_load, illegal_f3, misaligned, fault, rsp;
   logic [XLEN-1:0] load_data;

   assign accept  = wb.wb_valid & wb.wb_ready;
   assign is_load = (wb.wb_src == SRC_LOAD);
   assign rsp     = (state_q == WAIT_LOAD) & dmem_rvalid;

   always_comb begin
      illegal_f3 = 1'b0;
      case (wb.wb_funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_f3 = 1'b0;
         default:                                illegal_f3 = 1'b1;
      endcase
   end

   // funct3[1:0]==01 covers both LH and LHU.
   assign misaligned = ((wb.wb_funct3[1:0] == 2'b01) && wb.wb_alu_result[0]) ||
                       ((wb.wb_funct3 == 3'b010) && (wb.wb_alu_result[1:0] != 2'b00));
   assign fault      = accept & is_load & (illegal_f3 | misaligned);

   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b    = dmem_rdata[8*ld_addr_q +: 8];
      lane_h    = ld_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      case (ld_funct3_q)
         3'b000:  load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
         3'b001:  load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_b};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_h};
         default: load_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept && is_load && !fault) state_d = WAIT_LOAD;
         WAIT_LOAD: if (dmem_rvalid)                 state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      wb.wb_ready = (state_q == IDLE);
   end

   always_comb begin
      write_reg_d  = 1'b0;
      sel_d1_d     = sel_d1_q;
      reg_d1_d     = reg_d1_q;
      pend_valid_d = pend_valid_q;
      pend_rd_d    = pend_rd_q;
      ld_funct3_d  = ld_funct3_q;
      ld_addr_d    = ld_addr_q;
      load_fault_d = fault;
      spurious_d   = spurious_q | ((state_q == IDLE) & dmem_rvalid);
      if (accept && !is_load) begin
         if ((wb.wb_src != SRC_NONE) && (wb.wb_rd != 5'd0)) begin
            write_reg_d = 1'b1;
            sel_d1_d    = wb.wb_rd;
            reg_d1_d    = (wb.wb_src == SRC_PC4) ? wb.wb_pc4 : wb.wb_alu_result;
         end
      end else if (accept && !fault) begin
         pend_valid_d = 1'b1;
         pend_rd_d    = wb.wb_rd;
         ld_funct3_d  = wb.wb_funct3;
         ld_addr_d    = wb.wb_alu_result[1:0];
      end
      if (rsp) begin
         pend_valid_d = 1'b0;
         if (pend_rd_q != 5'd0) begin
            write_reg_d = 1'b1;
            sel_d1_d    = pend_rd_q;
            reg_d1_d    = load_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_reg_q  <= 1'b0;
         sel_d1_q     <= 5'd0;
         reg_d1_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_rd_q    <= 5'd0;
         ld_funct3_q  <= 3'd0;
         ld_addr_q    <= 2'd0;
         load_fault_q <= 1'b0;
         spurious_q   <= 1'b0;
      end else begin
         write_reg_q  <= write_reg_d;
         sel_d1_q     <= sel_d1_d;
         reg_d1_q     <= reg_d1_d;
         pend_valid_q <= pend_valid_d;
         pend_rd_q    <= pend_rd_d;
         ld_funct3_q  <= ld_funct3_d;
         ld_addr_q    <= ld_addr_d;
         load_fault_q <= load_fault_d;
         spurious_q   <= spurious_d;
      end
   end

   assign write_reg    = write_reg_q;
   assign sel_d1       = sel_d1_q;
   assign reg_d1       = reg_d1_q;
   assign pend_valid   = pend_valid_q;
   assign pend_rd      = pend_rd_q;
   assign load_fault   = load_fault_q;
   assign spurious_rsp = spurious_q;

`ifdef RV32_WB_PERF_EN
   // Faulted loads retire at accept; good loads retire on their response.
   logic                  retire;
   logic [PERF_WIDTH-1:0] instret_q, instret_d;

   assign retire    = (accept & (~is_load | fault)) | rsp;
   assign instret_d = instret_q + {{(PERF_WIDTH-1){1'b0}}, retire};

   always_ff @(posedge clk) begin
      if (rst) instret_q <= '0;
      else     instret_q <= instret_d;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif
endmodule

// File: tb/tb_rv32_writeback_unit.sv
// tb/tb_rv32_writeback_unit.sv - directed self-checking bench for rv32_writeback_unit
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rv32_writeback_unit;
   logic        clk;
   logic        rst;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        write_reg;
   logic [4:0]  sel_d1;
   logic [31:0] reg_d1;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        load_fault;
   logic        spurious_rsp;
   logic [31:0] instret;

   int vectors;
   int miscompares;
   int exp_instret;
   bit perf_en;

   rv32_writeback_unit_if #(.XLEN(32)) wb_if ();

   rv32_writeback_unit #(.XLEN(32), .PERF_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb           (wb_if.slave),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .write_reg    (write_reg),
      .sel_d1       (sel_d1),
      .reg_d1       (reg_d1),
      .pend_valid   (pend_valid),
      .pend_rd      (pend_rd),
      .load_fault   (load_fault),
      .spurious_rsp (spurious_rsp),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for exactly one accepting cycle.
   task automatic mem_issue(input logic [4:0] rd, input logic [1:0] src,
                            input logic [31:0] alu, input logic [31:0] pc4,
                            input logic [2:0] f3);
      wb_if.wb_valid      = 1'b1;
      wb_if.wb_rd         = rd;
      wb_if.wb_src        = src;
      wb_if.wb_alu_result = alu;
      wb_if.wb_pc4        = pc4;
      wb_if.wb_funct3     = f3;
      step();
      wb_if.wb_valid = 1'b0;
   endtask

   task automatic dmem_respond(input logic [31:0] data);
      dmem_rvalid = 1'b1;
      dmem_rdata  = data;
      step();
      dmem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_instret = 0;
      vectors++;
      if ({write_reg, sel_d1, reg_d1} !== 38'd0) begin
         miscompares++;
         $display("FAIL reset_write got %b/%0d/%h exp 0/0/00000000", write_reg, sel_d1, reg_d1);
      end
      vectors++;
      if ({wb_if.wb_ready, pend_valid, pend_rd, load_fault, spurious_rsp} !== 9'b1_0_00000_0_0) begin
         miscompares++;
         $display("FAIL reset_status got rdy=%b pv=%b prd=%0d lf=%b sp=%b exp rdy=1 rest 0",
                  wb_if.wb_ready, pend_valid, pend_rd, load_fault, spurious_rsp);
      end
      vectors++;
      if (instret !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_instret got %0d exp 0", instret);
      end
   endtask

   task automatic test_alu();
      mem_issue(5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 3'b000);
      exp_instret++;
      vectors++;
      if ({write_reg, sel_d1, reg_d1} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         miscompares++;
         $display("FAIL alu_write got %b/%0d/%h exp 1/5/deadbeef", write_reg, sel_d1, reg_d1);
      end
      step();
      vectors++;
      if ({write_reg, sel_d1, reg_d1} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         miscompares++;
         $display("FAIL alu_pulse_hold got %b/%0d/%h exp 0/5/deadbeef", write_reg, sel_d1, reg_d1);
      end
   endtask

   task automatic test_load(input string name, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [2:0] f3, input logic [31:0] rdata,
                            input logic [31:0] expv, input int waits);
      mem_issue(rd, 2'b01, addr, 32'h0, f3);
      for (int i = 0; i < waits; i++) begin
         vectors++;
         if ({wb_if.wb_ready, pend_valid, pend_rd, write_reg} !== {1'b0, 1'b1, rd, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_wait%0d got rdy=%b pv=%b prd=%0d wr=%b exp 0/1/%0d/0",
                     name, i, wb_if.wb_ready, pend_valid, pend_rd, write_reg, rd);
         end
         step();
      end
      dmem_respond(rdata);
      exp_instret++;
      vectors++;
      if ({write_reg, sel_d1, reg_d1, pend_valid, wb_if.wb_ready} !==
          {1'b1, rd, expv, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL %s_data got wr=%b rd=%0d d=%h pv=%b rdy=%b exp 1/%0d/%h/0/1",
                  name, write_reg, sel_d1, reg_d1, pend_valid, wb_if.wb_ready, rd, expv);
      end
   endtask

   task automatic test_fault(input string name, input logic [31:0] addr, input logic [2:0] f3);
      mem_issue(5'd9, 2'b01, addr, 32'h0, f3);
      exp_instret++;
      vectors++;
      if ({load_fault, write_reg, wb_if.wb_ready, pend_valid} !== 4'b1010) begin
         miscompares++;
         $display("FAIL %s_fault got lf=%b wr=%b rdy=%b pv=%b exp 1/0/1/0",
                  name, load_fault, write_reg, wb_if.wb_ready, pend_valid);
      end
      step();
      vectors++;
      if (load_fault !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_fault_pulse got %b exp 0", name, load_fault);
      end
   endtask

   task automatic test_no_write();
      mem_issue(5'd0, 2'b10, 32'h0, 32'h0000_1004, 3'b000);
      exp_instret++;
      vectors++;
      if (write_reg !== 1'b0) begin
         miscompares++;
         $display("FAIL jal_rd0 got wr=%b exp 0", write_reg);
      end
      mem_issue(5'd7, 2'b11, 32'h1234_5678, 32'h0, 3'b000);
      exp_instret++;
      vectors++;
      if ({write_reg, sel_d1, reg_d1} !== {1'b0, 5'd12, 32'hFFFFBEEF}) begin
         miscompares++;
         $display("FAIL src_none got %b/%0d/%h exp 0/12/ffffbeef", write_reg, sel_d1, reg_d1);
      end
      vectors++;
      if (instret !== (perf_en ? 32'(exp_instret) : 32'd0)) begin
         miscompares++;
         $display("FAIL instret_count got %0d exp %0d", instret, perf_en ? exp_instret : 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h0000_0011;
      vals[1] = 32'h0000_2000;
      vals[2] = 32'hCAFE_F00D;
      wb_if.wb_valid  = 1'b1;
      wb_if.wb_src    = 2'b00;
      wb_if.wb_funct3 = 3'b000;
      for (int i = 0; i < 3; i++) begin
         wb_if.wb_rd         = 5'(20 + i);
         wb_if.wb_alu_result = vals[i];
         wb_if.wb_src        = (i == 1) ? 2'b10 : 2'b00;
         wb_if.wb_pc4        = vals[i];
         step();
         exp_instret++;
         vectors++;
         if ({write_reg, sel_d1, reg_d1, wb_if.wb_ready} !== {1'b1, 5'(20 + i), vals[i], 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_%0d got %b/%0d/%h rdy=%b exp 1/%0d/%h rdy=1",
                     i, write_reg, sel_d1, reg_d1, wb_if.wb_ready, 20 + i, vals[i]);
         end
      end
      wb_if.wb_valid = 1'b0;
      vectors++;
      if (instret !== (perf_en ? 32'(exp_instret) : 32'd0)) begin
         miscompares++;
         $display("FAIL b2b_instret got %0d exp %0d", instret, perf_en ? exp_instret : 0);
      end
   endtask

   task automatic test_reset_mid_wait();
      mem_issue(5'd3, 2'b01, 32'h0000_0100, 32'h0, 3'b010);
      vectors++;
      if (pend_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_wait_pend got %b exp 1", pend_valid);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_instret = 0;
      vectors++;
      if ({pend_valid, wb_if.wb_ready, spurious_rsp} !== 3'b010) begin
         miscompares++;
         $display("FAIL rst_wait_clear got pv=%b rdy=%b sp=%b exp 0/1/0",
                  pend_valid, wb_if.wb_ready, spurious_rsp);
      end
      dmem_respond(32'h5555_AAAA);
      vectors++;
      if ({write_reg, spurious_rsp, pend_valid} !== 3'b010) begin
         miscompares++;
         $display("FAIL spurious_rsp got wr=%b sp=%b pv=%b exp 0/1/0", write_reg, spurious_rsp, pend_valid);
      end
      step();
      step();
      vectors++;
      if ({spurious_rsp, instret} !== {1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL spurious_sticky got sp=%b ir=%0d exp 1/0", spurious_rsp, instret);
      end
   endtask

   initial begin
`ifdef RV32_WB_PERF_EN
      perf_en = 1'b1;
`else
      perf_en = 1'b0;
`endif
      vectors             = 0;
      miscompares         = 0;
      exp_instret         = 0;
      rst                 = 1'b1;
      dmem_rvalid         = 1'b0;
      dmem_rdata          = 32'h0;
      wb_if.wb_valid      = 1'b0;
      wb_if.wb_rd         = 5'd0;
      wb_if.wb_src        = 2'b00;
      wb_if.wb_alu_result = 32'h0;
      wb_if.wb_pc4        = 32'h0;
      wb_if.wb_funct3     = 3'b000;
      test_reset();
      test_alu();
      test_load("lb",  5'd10, 32'h0000_1003, 3'b000, 32'h80FF_1234, 32'hFFFF_FF80, 3);
      test_load("lbu", 5'd11, 32'h0000_1001, 3'b100, 32'h80FF_9234, 32'h0000_0092, 1);
      test_load("lhu", 5'd12, 32'h0000_2002, 3'b101, 32'hBEEF_0000, 32'h0000_BEEF, 0);
      test_load("lw",  5'd13, 32'h0000_2000, 3'b010, 32'h1357_9BDF, 32'h1357_9BDF, 2);
      test_load("lh",  5'd12, 32'h0000_2002, 3'b001, 32'hBEEF_0000, 32'hFFFF_BEEF, 1);
      test_fault("lw_misalign", 32'h0000_3001, 3'b010);
      test_fault("lh_misalign", 32'h0000_3003, 3'b001);
      test_fault("f3_illegal",  32'h0000_3000, 3'b011);
      test_no_write();
      test_back_to_back();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
